interleave_sched: RTL and testbench

Round-robin scheduler that presents `NUM_BANKS` independent register FIFO banks as one wide-capacity, order-preserving FIFO. Writes are steered to banks in strict rotation and reads are collected in the same rotation, so each bank sees only every `NUM_BANKS`-th word. The block sits between the stream producer/consumer and the bank array. It owns bank sequencing, the aggregate occupancy count and clear/flush sequencing. It holds no data storage itself.

---
 rtl/interleave_sched.sv | 106 ++++++++++
 tb/tb_interleave_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/interleave_sched.sv
// Round-robin scheduler that makes NUM_BANKS register FIFO banks behave as one
// order-preserving FIFO. Holds bank pointers, aggregate count and flush sequencing.

module interleave_sched_lane (
  input  logic wr_hit,
  input  logic rd_hit,
  input  logic push,
  input  logic pop,
  output logic in_stb,
  output logic out_stb
);
  assign in_stb  = wr_hit & push;
  assign out_stb = rd_hit & pop;
endmodule

module interleave_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 4,
  localparam int PW = $clog2(NUM_BANKS),
  localparam int CW = $clog2(NUM_BANKS*BANK_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            clear,
  output logic [CW-1:0]                   count,
  output logic [DATA_WIDTH-1:0]           bank_in_data,
  output logic [NUM_BANKS-1:0]            bank_in_valid,
  input  logic [NUM_BANKS-1:0]            bank_in_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_out_data,
  input  logic [NUM_BANKS-1:0]            bank_out_valid,
  output logic [NUM_BANKS-1:0]            bank_out_ready,
  output logic                            bank_clear
);

  typedef enum logic {FLUSH, RUN} state_t;

  state_t state, state_nxt;
  logic [PW-1:0] wr_sel, rd_sel;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_words;
  logic run, push, pop;

  assign bank_words   = bank_out_data;
  assign bank_in_data = in_data;
  assign out_data     = bank_words[rd_sel];

  always_ff @(posedge clk) begin
    if (rst) state <= FLUSH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FLUSH:   state_nxt = clear ? FLUSH : RUN;
      RUN:     if (clear) state_nxt = FLUSH;
      default: state_nxt = FLUSH;
    endcase
  end

  // Readiness comes only from the currently selected bank; never skipping a
  // stalled bank is what keeps the global order intact.
  always_comb begin
    run        = (state == RUN);
    bank_clear = ~run;
    in_ready   = run & bank_in_ready[wr_sel] & ~clear;
    out_valid  = run & bank_out_valid[rd_sel] & ~clear;
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
    interleave_sched_lane u_lane (
      .wr_hit  (wr_sel == PW'(i)),
      .rd_hit  (rd_sel == PW'(i)),
      .push    (push),
      .pop     (pop),
      .in_stb  (bank_in_valid[i]),
      .out_stb (bank_out_ready[i])
    );
  end

  // NUM_BANKS is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_sel <= '0;
      rd_sel <= '0;
      count  <= '0;
    end else begin
      if (push) wr_sel <= wr_sel + PW'(1);
      if (pop)  rd_sel <= rd_sel + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_interleave_sched.sv
// Bench: behavioural register-FIFO banks around the scheduler, randomized and
// directed traffic, with a whole-FIFO queue model scoring every cycle.

module tb_interleave_sched;
  localparam int NB = 4, DW = 8, BD = 4, CW = $clog2(NB*BD) + 1;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, clear = 0, stub2 = 0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready, out_valid, bank_clear;
  logic [DW-1:0]    out_data, bank_in_data;
  logic [CW-1:0]    count;
  logic [NB-1:0]    bank_in_valid, bank_in_ready, bank_out_valid, bank_out_ready;
  logic [NB*DW-1:0] bank_out_data;

  int tests = 0, fails = 0;

  interleave_sched #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .clear(clear),
    .count(count), .bank_in_data(bank_in_data), .bank_in_valid(bank_in_valid),
    .bank_in_ready(bank_in_ready), .bank_out_data(bank_out_data),
    .bank_out_valid(bank_out_valid), .bank_out_ready(bank_out_ready), .bank_clear(bank_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bank array: simple register FIFOs, depth BD each.
  logic [DW-1:0] bmem [NB][BD];
  int bcnt [NB], brp [NB], bwp [NB];

  always_comb begin
    bank_in_ready  = '0;
    bank_out_valid = '0;
    bank_out_data  = '0;
    for (int i = 0; i < NB; i++) begin
      bank_in_ready[i]            = (bcnt[i] < BD) && !(stub2 && i == 2);
      bank_out_valid[i]           = (bcnt[i] != 0);
      bank_out_data[i*DW +: DW]   = bmem[i][brp[i]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (rst || bank_clear) begin
        bcnt[i] <= 0; brp[i] <= 0; bwp[i] <= 0;
      end else begin
        if (bank_in_valid[i]) begin
          bmem[i][bwp[i]] <= bank_in_data;
          bwp[i] <= (bwp[i] + 1) % BD;
        end
        if (bank_out_ready[i]) brp[i] <= (brp[i] + 1) % BD;
        bcnt[i] <= bcnt[i] + (bank_in_valid[i] ? 1 : 0) - (bank_out_ready[i] ? 1 : 0);
      end
    end
  end

  // Reference: one FIFO queue plus rotation positions counted in words.
  initial begin
    bit m_flush, mon_en;
    int m_wp, m_rp;
    logic e_ir, e_ov, e_push, e_pop;
    logic [DW-1:0] sb [$];
    m_flush = 1; mon_en = 0; m_wp = 0; m_rp = 0;
    forever begin
      @(negedge clk);
      e_ir = 0; e_ov = 0; e_push = 0; e_pop = 0;
      if (mon_en) begin
        e_ir   = !m_flush && bank_in_ready[m_wp] && !clear;
        e_ov   = !m_flush && bank_out_valid[m_rp] && !clear;
        e_push = in_valid && e_ir;
        e_pop  = out_ready && e_ov;
        chk("in_ready", in_ready, e_ir);
        chk("out_valid", out_valid, e_ov);
        chk("bank_clear", bank_clear, m_flush);
        chk("count", count, sb.size());
        chk("bank_in_valid", bank_in_valid, e_push ? (1 << m_wp) : 0);
        chk("bank_out_ready", bank_out_ready, e_pop ? (1 << m_rp) : 0);
        chk("bank_in_data", bank_in_data, in_data);
        if (e_pop) begin
          if (sb.size() > 0) chk("out_data", out_data, sb.pop_front());
          else chk("out_valid_when_empty", out_valid, 0);
        end
      end
      if (rst || clear) begin
        m_flush = 1; m_wp = 0; m_rp = 0; sb.delete();
        if (rst) mon_en = 1;
      end else begin
        m_flush = 0;
        if (e_pop) m_rp = (m_rp + 1) % NB;
        if (e_push) begin
          sb.push_back(in_data);
          m_wp = (m_wp + 1) % NB;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; out_ready = 1;
    while (count != 0 && n < 40) begin step(); n++; end
    chk("drain_done", count, 0);
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_bank_clear", bank_clear, 1);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    step(); rst = 0;
    @(negedge clk); chk("release1_in_ready", in_ready, 0);
    @(negedge clk); chk("release2_in_ready", in_ready, 1);

    // fill all banks in rotation
    step();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = DW'($urandom);
      @(negedge clk); chk("push_strobe", bank_in_valid, 1 << (i % NB));
      step();
    end
    in_valid = 0;
    @(negedge clk); chk("full_count", count, 16); chk("full_in_ready", in_ready, 0);

    step(); out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); chk("pop_strobe", bank_out_ready, 1 << (i % NB));
      step();
    end
    out_ready = 0;
    @(negedge clk); chk("empty_count", count, 0); chk("empty_out_valid", out_valid, 0);

    // steady push+pop at count 5 across wrap
    step(); in_valid = 1;
    repeat (5) begin in_data = DW'($urandom); step(); end
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = DW'($urandom);
      @(negedge clk); chk("steady_count", count, 5);
      step();
    end
    drain();

    // wr_sel now 1; one push brings it to bank 2, which is then stalled
    in_valid = 1; in_data = DW'($urandom); step();
    stub2 = 1; in_data = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_strobe", bank_in_valid, 0);
      step();
    end
    stub2 = 0;
    @(negedge clk); chk("stall_resume", bank_in_valid, 4'b0100);
    step();
    drain();

    // clear with traffic pending
    in_valid = 1;
    repeat (7) begin in_data = DW'($urandom); step(); end
    out_ready = 1; clear = 1;
    @(negedge clk);
    chk("clr_count7", count, 7);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_strobe", bank_in_valid, 0);
    chk("clr_out_strobe", bank_out_ready, 0);
    step(); clear = 0; in_valid = 0; out_ready = 0;
    @(negedge clk); chk("flush_bank_clear", bank_clear, 1); chk("flush_count", count, 0);
    step(); in_valid = 1; in_data = DW'($urandom);
    @(negedge clk); chk("post_clear_bank0", bank_in_valid, 4'b0001);
    step();
    drain();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 49) == 0);
      stub2     = ($urandom_range(0, 9) == 0);
      rst       = (c == 200);
      in_data   = DW'($urandom);
      step();
    end
    rst = 0; clear = 0; stub2 = 0;
    step();
    drain();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
